fc_event_irq_unit: RTL
======================

Name: fc_event_irq_unit

Overview:
- Parametrised interrupt and event front-end for the FC core.
- Latches N event lines and a soc-event FIFO into per-line pending bits.
- Masks the pending bits, selects the highest-priority one, and drives both an ID/req pair and a one-hot irq vector, so one block serves cv32e40p-style and Ibex-style cores.
- Clears pending state on core ack.
- Sits between the SoC event generator/FIFO and the core irq inputs, replacing fixed 32-line/fixed-ID remapping with configurable line count, FIFO depth and FIFO irq slot.

Parameters:
NB_IRQ, 32, number of irq lines (2..64).
IRQ_ID_WIDTH, $clog2(NB_IRQ), width of irq IDs.
EVENT_ID_WIDTH, 8, width of soc-event FIFO entries.
FIFO_DEPTH, 4, soc-event FIFO entries (power of 2, >=2).
FIFO_IRQ_ID, 26, irq line driven by FIFO non-empty; must be < NB_IRQ.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
events_i  in  NB_IRQ  event pulses/levels; each sampled high cycle sets the pending bit
irq_mask_i  in  NB_IRQ  1 = line enabled
event_fifo_valid_i  in  1  soc event push
event_fifo_data_i  in  EVENT_ID_WIDTH  soc event ID
event_fifo_fulln_o  out  1  1 = FIFO can accept
irq_req_o  out  1  masked interrupt pending
irq_id_o  out  IRQ_ID_WIDTH  ID of selected interrupt
irq_lines_o  out  NB_IRQ  one-hot of selected irq (all-zero when irq_req_o=0)
irq_ack_i  in  1  core acknowledges an interrupt
irq_ack_id_i  in  IRQ_ID_WIDTH  ID being acknowledged
fifo_head_o  out  EVENT_ID_WIDTH  oldest FIFO entry (0 when empty)
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
pending_o  out  NB_IRQ  raw pending vector, unmasked, FIFO bit included

Behaviour:
Reset (rst_i high at a clk_i edge):
- pending=0, FIFO empty (rd/wr ptr=0, count=0).
- All outputs 0 except event_fifo_fulln_o=1.
- Reset mid-operation discards all pending bits and FIFO contents; any ack in the reset cycle is ignored.

Pending register, bits k != FIFO_IRQ_ID:
- Next = (pending[k] & ~clr[k]) | events_i[k].
- clr[k] = irq_ack_i & (irq_ack_id_i == k).
- Set wins over simultaneous clear, so an event is never lost.
- events_i[FIFO_IRQ_ID] is ignored.

FIFO-backed bit:
- pending[FIFO_IRQ_ID] = (count != 0), combinational from registered count.

FIFO:
- Push when event_fifo_valid_i & event_fifo_fulln_o.
- Pop when irq_ack_i & irq_ack_id_i==FIFO_IRQ_ID & count!=0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pop on empty: ignored. Push when full: dropped. The producer must honour fulln.
- event_fifo_fulln_o = (count != FIFO_DEPTH), from registered count.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_head_o = mem[rd_ptr] when count!=0, else 0.

Selection (combinational from registered pending and mask):
- act = pending & irq_mask_i.
- irq_req_o = |act.
- irq_id_o = highest index k with act[k]=1; 0 when none.
- irq_lines_o = one-hot of irq_id_o, gated by irq_req_o.

Latency:
- events_i high at edge N → irq_req_o/irq_id_o valid after edge N (1 cycle).
- Ack at edge M → bit cleared and selection updated after edge M.
- Next-priority irq presented the cycle after the ack.

Mask:
- A masked pending bit stays pending.
- Unmasking later raises irq_req_o in the same cycle (combinational).

Ack edge cases:
- Ack of a non-pending ID (other than FIFO_IRQ_ID) has no effect.
- Ack of an ID >= NB_IRQ is ignored.

No internal state machine beyond the pending/FIFO registers; all updates happen on clk_i rising edges.

Test Plan:
1. Reset, then events_i[3]=1 for 1 cycle, mask all ones → next cycle irq_req_o=1, irq_id_o=3, irq_lines_o=0x8; ack id 3 → irq_req_o=0 the cycle after.
2. events_i[5] and events_i[20] pulse together, mask all ones → irq_id_o=20; ack 20 → irq_id_o=5 next cycle; ack 5 → irq_req_o=0.
3. events_i[7] high in the same cycle as ack id 7 while bit 7 pending → pending_o[7] stays 1, irq_id_o=7 next cycle.
4. Push 0x11, 0x22, 0x33, 0x44 (DEPTH=4) → fulln_o=0, count=4; 5th push 0x55 dropped; ack 26 four times → fifo_head_o 0x22, 0x33, 0x44, 0 in turn; irq_req_o drops after the 4th ack; a 5th ack is ignored.
5. FIFO full, push and pop (ack 26) in the same cycle → push refused, count=3. Count=2, push and pop together → count stays 2, head advances.
6. Mask[9]=0 with events_i[9] pulsed → irq_req_o=0, pending_o[9]=1; set mask[9]=1 → irq_req_o=1, id=9 the same cycle. Assert rst_i with pending bits and 2 FIFO entries → everything 0 and fulln=1 after the edge.

Source files
------------

// File: rtl/fc_event_irq_unit.sv
// Event/interrupt front-end: latches event lines and a soc-event FIFO into pending bits and presents the highest masked one.
// Latency: one cycle from event or ack to updated selection; the FIFO refuses pushes while full (fulln low) and drops them.

module fc_event_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  output logic                   push_rdy,
  input  logic                   pop_vld,
  output logic [WIDTH-1:0]       head_dat,
  output logic [COUNT_WIDTH-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_rdy = (count != COUNT_WIDTH'(DEPTH));
  assign push_ok  = push_vld & push_rdy;
  assign pop_ok   = pop_vld & (count != '0);
  assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + COUNT_WIDTH'(push_ok) - COUNT_WIDTH'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

module fc_event_irq_unit #(
  parameter int NB_IRQ         = 32,
  parameter int IRQ_ID_WIDTH   = $clog2(NB_IRQ),
  parameter int EVENT_ID_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_IRQ_ID    = 26
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_IRQ-1:0]            events_i,
  input  logic [NB_IRQ-1:0]            irq_mask_i,
  input  logic                         event_fifo_valid_i,
  input  logic [EVENT_ID_WIDTH-1:0]    event_fifo_data_i,
  output logic                         event_fifo_fulln_o,
  output logic                         irq_req_o,
  output logic [IRQ_ID_WIDTH-1:0]      irq_id_o,
  output logic [NB_IRQ-1:0]            irq_lines_o,
  input  logic                         irq_ack_i,
  input  logic [IRQ_ID_WIDTH-1:0]      irq_ack_id_i,
  output logic [EVENT_ID_WIDTH-1:0]    fifo_head_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic [NB_IRQ-1:0]            pending_o
);
  logic [NB_IRQ-1:0] pend_q;
  logic [NB_IRQ-1:0] clr;
  logic [NB_IRQ-1:0] act;
  logic [NB_IRQ-1:0] fifo_bit;
  logic              fifo_pop;

  assign fifo_bit = NB_IRQ'(1) << FIFO_IRQ_ID;
  assign fifo_pop = irq_ack_i && (irq_ack_id_i == IRQ_ID_WIDTH'(FIFO_IRQ_ID));

  fc_event_fifo #(
    .WIDTH       (EVENT_ID_WIDTH),
    .DEPTH       (FIFO_DEPTH),
    .COUNT_WIDTH ($clog2(FIFO_DEPTH) + 1)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (event_fifo_valid_i),
    .push_dat (event_fifo_data_i),
    .push_rdy (event_fifo_fulln_o),
    .pop_vld  (fifo_pop),
    .head_dat (fifo_head_o),
    .count    (fifo_count_o)
  );

  // IDs at or above NB_IRQ match no line and therefore clear nothing.
  always_comb begin
    clr = '0;
    for (int k = 0; k < NB_IRQ; k++) begin
      clr[k] = irq_ack_i && (irq_ack_id_i == IRQ_ID_WIDTH'(k));
    end
  end

  // The FIFO slot is never stored here; it mirrors FIFO occupancy instead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= ((pend_q & ~clr) | events_i) & ~fifo_bit;
    end
  end

  assign pending_o = pend_q | ((fifo_count_o != '0) ? fifo_bit : '0);
  assign act       = pending_o & irq_mask_i;
  assign irq_req_o = |act;

  always_comb begin
    irq_id_o = '0;
    for (int k = 0; k < NB_IRQ; k++) begin
      if (act[k]) irq_id_o = IRQ_ID_WIDTH'(k);
    end
  end

  assign irq_lines_o = irq_req_o ? (NB_IRQ'(1) << irq_id_o) : '0;
endmodule
